// File: rtl/mix_vga_agc_ctrl.sv
// Mixer VGA AGC: windowed peak detect, +/-1 gain step per window, settle holdoff, host override.
// Optional MIX_AGC_HYST_EN: only step after two consecutive windows ask for the same direction.
module mix_vga_agc_ctrl #(
   parameter int INPUT_WIDTH = 3,
   parameter int MAG_WIDTH   = 8,
   parameter int WIN_LEN     = 16,
   parameter int SETTLE_CYC  = 32,
   parameter int MAX_CODE    = 6,
   parameter int INIT_CODE   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   sample_valid,
   input  logic [MAG_WIDTH-1:0]   sample_mag,
   input  logic [MAG_WIDTH-1:0]   thr_hi,
   input  logic [MAG_WIDTH-1:0]   thr_lo,
   input  logic                   manual_en,
   input  logic [INPUT_WIDTH-1:0] manual_code,
   output logic [INPUT_WIDTH-1:0] gain_code,
   output logic [5:0]             vga_control_out,
   output logic                   busy,
   output logic                   locked
);

   localparam int WCW = $clog2(WIN_LEN + 1);
   localparam int SCW = $clog2(SETTLE_CYC + 1);
   localparam logic [INPUT_WIDTH-1:0] MAX_C  = INPUT_WIDTH'(MAX_CODE);
   localparam logic [INPUT_WIDTH-1:0] INIT_C = INPUT_WIDTH'(INIT_CODE);

   typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, SETTLE} state_t;

   state_t                 state;
   logic [MAG_WIDTH-1:0]   peak;
   logic [MAG_WIDTH-1:0]   peak_max;
   logic [WCW-1:0]         win_cnt;
   logic [SCW-1:0]         set_cnt;
   logic                   req_dn, req_up, in_band, do_step;
   logic [INPUT_WIDTH-1:0] next_code, man_code;
`ifdef MIX_AGC_HYST_EN
   logic                   last_dir;   // 1 = last request was a step down
   logic                   pending;
`endif

   function automatic logic [5:0] therm(input logic [INPUT_WIDTH-1:0] c);
      logic [6:0] t;
      t = (7'd1 << c) - 7'd1;
      return t[5:0];
   endfunction

   always_comb begin
      peak_max = (sample_mag > peak) ? sample_mag : peak;
      req_dn   = (peak > thr_hi);
      req_up   = !req_dn && (peak < thr_lo);
      in_band  = !req_dn && !req_up;
`ifdef MIX_AGC_HYST_EN
      do_step  = (req_dn || req_up) && pending && (last_dir == req_dn);
`else
      do_step  = req_dn || req_up;
`endif
      next_code = gain_code;
      if (do_step && req_dn && (gain_code != '0))
         next_code = gain_code - 1'b1;
      else if (do_step && req_up && (gain_code < MAX_C))
         next_code = gain_code + 1'b1;
      man_code = (manual_code > MAX_C) ? MAX_C : manual_code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         gain_code       <= INIT_C;
         vga_control_out <= therm(INIT_C);
         busy            <= 1'b0;
         locked          <= 1'b0;
         peak            <= '0;
         win_cnt         <= '0;
         set_cnt         <= '0;
`ifdef MIX_AGC_HYST_EN
         last_dir        <= 1'b0;
         pending         <= 1'b0;
`endif
      end else if (manual_en) begin
         state           <= IDLE;
         gain_code       <= man_code;
         vga_control_out <= therm(man_code);
         busy            <= 1'b0;
         locked          <= 1'b0;
`ifdef MIX_AGC_HYST_EN
         pending         <= 1'b0;
`endif
      end else if (!en) begin
         state <= IDLE;
         busy  <= 1'b0;
`ifdef MIX_AGC_HYST_EN
         pending <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state   <= MEASURE;
               busy    <= 1'b1;
               peak    <= '0;
               win_cnt <= '0;
`ifdef MIX_AGC_HYST_EN
               pending <= 1'b0;
`endif
            end
            MEASURE: begin
               if (sample_valid) begin
                  peak <= peak_max;
                  if (win_cnt == WCW'(WIN_LEN - 1)) begin
                     state   <= DECIDE;
                     win_cnt <= '0;
                  end else begin
                     win_cnt <= win_cnt + 1'b1;
                  end
               end
            end
            DECIDE: begin
               gain_code       <= next_code;
               vga_control_out <= therm(next_code);
               locked          <= in_band;
`ifdef MIX_AGC_HYST_EN
               // a second request either steps or cancels; both end the pending pair
               if (in_band || pending) begin
                  pending <= 1'b0;
               end else begin
                  pending  <= 1'b1;
                  last_dir <= req_dn;
               end
`endif
               if (next_code != gain_code) begin
                  state   <= SETTLE;
                  set_cnt <= '0;
               end else begin
                  state   <= MEASURE;
                  peak    <= '0;
                  win_cnt <= '0;
               end
            end
            SETTLE: begin
               if (set_cnt == SCW'(SETTLE_CYC - 1)) begin
                  state   <= MEASURE;
                  set_cnt <= '0;
                  peak    <= '0;
                  win_cnt <= '0;
               end else begin
                  set_cnt <= set_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_vga_agc_ctrl.sv
// Directed bench for mix_vga_agc_ctrl: window table plus enable/manual/reset corner sequences.
module tb_mix_vga_agc_ctrl;

   logic       clk = 1'b0;
   logic       rst, en, sample_valid, manual_en;
   logic [7:0] sample_mag, thr_hi, thr_lo;
   logic [2:0] manual_code;
   logic [2:0] gain_code;
   logic [5:0] vga_control_out;
   logic       busy, locked;

   int checks   = 0;
   int failures = 0;
   int cur_code;

   always #5 clk = ~clk;

   mix_vga_agc_ctrl dut (
      .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
      .sample_mag(sample_mag), .thr_hi(thr_hi), .thr_lo(thr_lo),
      .manual_en(manual_en), .manual_code(manual_code),
      .gain_code(gain_code), .vga_control_out(vga_control_out),
      .busy(busy), .locked(locked)
   );

   typedef struct {
      int mag;     // window sample magnitude
      int gap;     // 1: sample_valid toggles every other cycle
      int spike;   // 1: sample 7 of the window is 250
      int code;    // expected code after DECIDE
      int vga;     // expected thermometer word
      int lock;    // expected locked
      int settle;  // 1: code changes, SETTLE follows
   } vec_t;

   vec_t tbl[13];

   task automatic cyc;
      @(negedge clk);
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Starts with the DUT in MEASURE with an empty window.
   task automatic run_window(input string nm, input int mag, input int gap, input int spike,
                             input int ecode, input int evga, input int elock, input int esettle);
      for (int i = 0; i < 16; i++) begin
         sample_valid = 1'b1;
         sample_mag   = (spike != 0 && i == 7) ? 8'd250 : 8'(mag);
         cyc;
         if (gap != 0 && i != 15) begin
            sample_valid = 1'b0;
            sample_mag   = 8'd255;
            cyc;
         end
      end
      sample_valid = 1'b0;
      check({nm, " code_in_decide"}, int'(gain_code), cur_code);
      cyc;
      check({nm, " code"}, int'(gain_code), ecode);
      check({nm, " vga"}, int'(vga_control_out), evga);
      check({nm, " locked"}, int'(locked), elock);
      check({nm, " busy"}, int'(busy), 1);
      if (esettle != 0) begin
         // full-scale samples here must not reach the next window
         for (int i = 0; i < 32; i++) begin
            sample_valid = 1'b1;
            sample_mag   = 8'd255;
            cyc;
         end
         sample_valid = 1'b0;
      end
      cur_code = ecode;
   endtask

   initial begin
      tbl[0]  = '{200, 0, 0, 2, 'h03, 0, 1};
      tbl[1]  = '{ 10, 0, 0, 3, 'h07, 0, 1};
      tbl[2]  = '{ 10, 0, 0, 4, 'h0F, 0, 1};
      tbl[3]  = '{ 10, 0, 0, 5, 'h1F, 0, 1};
      tbl[4]  = '{ 10, 0, 0, 6, 'h3F, 0, 1};
      tbl[5]  = '{ 10, 0, 0, 6, 'h3F, 0, 0};
      tbl[6]  = '{100, 1, 0, 6, 'h3F, 1, 0};
      tbl[7]  = '{100, 0, 1, 5, 'h1F, 0, 1};
      tbl[8]  = '{180, 0, 0, 5, 'h1F, 1, 0};
      tbl[9]  = '{ 60, 0, 0, 5, 'h1F, 1, 0};
      tbl[10] = '{181, 0, 0, 4, 'h0F, 0, 1};
      tbl[11] = '{ 59, 0, 0, 5, 'h1F, 0, 1};
      tbl[12] = '{100, 0, 0, 5, 'h1F, 1, 0};

      rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_mag = 8'd0;
      thr_hi = 8'd180; thr_lo = 8'd60; manual_en = 1'b0; manual_code = 3'd0;
      cyc; cyc;
      check("reset code", int'(gain_code), 3);
      check("reset vga", int'(vga_control_out), 'h07);
      check("reset busy", int'(busy), 0);
      check("reset locked", int'(locked), 0);

      rst = 1'b0; en = 1'b1;
      cyc;
      check("start busy", int'(busy), 1);
      cur_code = 3;

`ifdef MIX_AGC_HYST_EN
      run_window("hy_first_hi",  200, 0, 0, 3, 'h07, 0, 0);
      run_window("hy_second_hi", 200, 0, 0, 2, 'h03, 0, 1);
      run_window("hy_pend_hi",   200, 0, 0, 2, 'h03, 0, 0);
      run_window("hy_opposite",   10, 0, 0, 2, 'h03, 0, 0);
      run_window("hy_first_lo",   10, 0, 0, 2, 'h03, 0, 0);
      run_window("hy_second_lo",  10, 0, 0, 3, 'h07, 0, 1);
      run_window("hy_inband",    100, 0, 0, 3, 'h07, 1, 0);
`else
      for (int i = 0; i < 13; i++)
         run_window($sformatf("win%0d", i), tbl[i].mag, tbl[i].gap, tbl[i].spike,
                    tbl[i].code, tbl[i].vga, tbl[i].lock, tbl[i].settle);

      en = 1'b0;
      cyc;
      check("en_off busy", int'(busy), 0);
      check("en_off code", int'(gain_code), 5);
      check("en_off locked", int'(locked), 1);
      en = 1'b1;
      cyc;
      check("en_on busy", int'(busy), 1);

      manual_en = 1'b1; manual_code = 3'd7;
      cyc;
      check("man7 code", int'(gain_code), 6);
      check("man7 vga", int'(vga_control_out), 'h3F);
      check("man7 locked", int'(locked), 0);
      check("man7 busy", int'(busy), 0);
      manual_code = 3'd0;
      cyc;
      check("man0 code", int'(gain_code), 0);
      check("man0 vga", int'(vga_control_out), 'h00);
      manual_en = 1'b0;
      cyc;
      check("man_rel busy", int'(busy), 1);
      check("man_rel code", int'(gain_code), 0);
      cur_code = 0;
      run_window("sat_dn", 200, 0, 0, 0, 'h00, 0, 0);
      run_window("from0_up", 10, 0, 0, 1, 'h01, 0, 1);

      for (int i = 0; i < 16; i++) begin
         sample_valid = 1'b1; sample_mag = 8'd10;
         cyc;
      end
      sample_valid = 1'b0;
      cyc;
      check("pre_rst code", int'(gain_code), 2);
      for (int i = 0; i < 9; i++) cyc;
      rst = 1'b1;
      cyc;
      check("rst_settle code", int'(gain_code), 3);
      check("rst_settle vga", int'(vga_control_out), 'h07);
      check("rst_settle busy", int'(busy), 0);
      check("rst_settle locked", int'(locked), 0);
      rst = 1'b0;
      cyc;
      check("post_rst busy", int'(busy), 1);
      cur_code = 3;
      run_window("post_rst_dn", 200, 0, 0, 2, 'h03, 0, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
